// File: rtl/regfile_reader.sv
// Dual-operand read side of the 32x32 register file: per-operand r0/bypass select,
// snapshot into a 2-entry circular buffer, valid/ready hand-off to decode/execute.

module regfile_operand_sel (
    input  logic [4:0]    addr_i,
    input  logic [1023:0] reg_bus_i,
    input  logic          wr_en_i,
    input  logic [4:0]    wr_addr_i,
    input  logic [31:0]   wr_data_i,
    output logic [31:0]   data_o
);
    always_comb begin
        data_o = reg_bus_i[32*addr_i +: 32];
        // r0 wins over the write port, so a write to r0 can never leak through
        if (addr_i == 5'd0)
            data_o = 32'h0;
        else if (wr_en_i && (wr_addr_i == addr_i))
            data_o = wr_data_i;
    end
endmodule

module regfile_reader (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [1023:0] reg_bus_i,
    input  logic          wr_en_i,
    input  logic [4:0]    wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [4:0]    rs_a_i,
    input  logic [4:0]    rs_b_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   out_a_o,
    output logic [31:0]   out_b_o,
    output logic [15:0]   rd_count_o
);
    localparam int DEPTH   = 2;
    localparam int NUM_OPS = 2;

    logic [NUM_OPS-1:0][4:0]             rs;
    logic [NUM_OPS-1:0][31:0]            sel;
    logic [DEPTH-1:0][NUM_OPS-1:0][31:0] buf_q, buf_d;
    logic [NUM_OPS-1:0][31:0]            last_q, last_d, head;
    logic                                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]                          count_q, count_d;
    logic [15:0]                         rd_count_q, rd_count_d;
    logic                                push, pop;

    assign rs[0] = rs_a_i;
    assign rs[1] = rs_b_i;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        regfile_operand_sel u_sel (
            .addr_i    (rs[g]),
            .reg_bus_i (reg_bus_i),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .data_o    (sel[g])
        );
    end

    assign req_ready_o = (count_q < 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // An empty buffer shows the last popped pair rather than a stale slot
    assign head     = out_valid_o ? buf_q[rd_ptr_q] : last_q;
    assign out_a_o  = head[0];
    assign out_b_o  = head[1];
    assign rd_count_o = rd_count_q;

    always_comb begin
        buf_d      = buf_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_count_d = rd_count_q;
        if (push) begin
            buf_d[wr_ptr_q] = sel;
            wr_ptr_d        = ~wr_ptr_q;
            rd_count_d      = rd_count_q + 16'd1;
        end
        if (pop) begin
            last_d   = buf_q[rd_ptr_q];
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q      <= '0;
            last_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rd_count_q <= 16'd0;
        end else begin
            buf_q      <= buf_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_count_q <= rd_count_d;
        end
    end
endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: queue-based reference model checked every
// negedge, plus literal expectations at key points of each scenario.

module tb_regfile_reader;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] reg_bus;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    rs_a, rs_b;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_a, out_b;
    logic [15:0]   rd_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_reader dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .reg_bus_i   (reg_bus),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .rs_a_i      (rs_a),
        .rs_b_i      (rs_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .rd_count_o  (rd_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of captured pairs, last popped pair, accept counter
    logic [63:0] mq[$];
    logic [63:0] m_last;
    logic [15:0] m_cnt;

    function automatic logic [31:0] operand(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return reg_bus[32*a +: 32];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 64'h0;
            m_cnt  = 16'h0;
        end else begin
            logic acc, pp;
            acc = req_valid && (mq.size() < 2);
            pp  = out_ready && (mq.size() != 0);
            if (pp) m_last = mq.pop_front();
            if (acc) begin
                mq.push_back({operand(rs_a), operand(rs_b)});
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] exp_pair;
        exp_pair = (mq.size() != 0) ? mq[0] : m_last;
        chk("m_out_valid", out_valid, mq.size() != 0);
        chk("m_req_ready", req_ready, mq.size() < 2);
        chk("m_out_pair", {out_a, out_b}, exp_pair);
        chk("m_rd_count", rd_count, m_cnt);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        reg_bus[32*r +: 32] = v;
    endtask

    initial begin
        rst_n = 1'b0; reg_bus = '0; wr_en = 0; wr_addr = 0; wr_data = 0;
        req_valid = 0; rs_a = 0; rs_b = 0; out_ready = 0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_rd_count", rd_count, 0);
        step; step;
        rst_n = 1'b1;

        // Basic read
        set_reg(5, 32'h0000_00A5); set_reg(9, 32'hDEAD_BEEF);
        req_valid = 1; rs_a = 5; rs_b = 9;
        step;
        req_valid = 0;
        chk("basic_valid", out_valid, 1);
        chk("basic_a", out_a, 32'h0000_00A5);
        chk("basic_b", out_b, 32'hDEAD_BEEF);
        chk("basic_cnt", rd_count, 1);
        out_ready = 1;
        step;
        out_ready = 0;
        chk("hold_valid", out_valid, 0);
        chk("hold_a", out_a, 32'h0000_00A5);

        // r0 and bypass
        set_reg(7, 32'h0);
        wr_en = 1; wr_addr = 7; wr_data = 32'h1234_5678;
        req_valid = 1; rs_a = 7; rs_b = 0; out_ready = 1;
        step;
        chk("byp_a", out_a, 32'h1234_5678);
        chk("byp_b", out_b, 32'h0);
        wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        step;
        chk("r0w_a", out_a, 32'h0);
        chk("r0w_b", out_b, 32'h0);
        req_valid = 0; wr_en = 0;
        step;
        chk("r0w_cnt", rd_count, 3);

        // Full / backpressure
        out_ready = 0;
        set_reg(1, 1); set_reg(2, 2); set_reg(3, 3);
        req_valid = 1; rs_a = 1; rs_b = 1;
        step;
        rs_a = 2; rs_b = 2;
        step;
        chk("full_ready", req_ready, 0);
        chk("full_cnt", rd_count, 5);
        rs_a = 3; rs_b = 3;
        step;
        chk("full_ready2", req_ready, 0);
        chk("full_cnt2", rd_count, 5);
        chk("full_head", out_a, 1);
        out_ready = 1;
        step;
        chk("pop1_head", out_a, 2);
        chk("pop1_ready", req_ready, 1);
        step;
        chk("pop2_head", out_a, 3);
        chk("pop2_cnt", rd_count, 6);
        req_valid = 0;
        step;
        chk("drain_valid", out_valid, 0);

        // Simultaneous push/pop at count 1
        for (int r = 10; r < 32; r++) set_reg(r, 32'h100 + r);
        out_ready = 0; req_valid = 1; rs_a = 10; rs_b = 11;
        step;
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            rs_a = 5'(12 + i); rs_b = 5'(31 - i);
            step;
            chk("pp_valid", out_valid, 1);
            chk("pp_ready", req_ready, 1);
        end
        chk("pp_last_a", out_a, 32'h100 + 21);
        chk("pp_last_b", out_b, 32'h100 + 22);
        req_valid = 0;
        step;

        // Snapshot
        out_ready = 0;
        set_reg(4, 32'hAAAA_AAAA);
        req_valid = 1; rs_a = 4; rs_b = 4;
        step;
        req_valid = 0;
        set_reg(4, 32'h5555_5555);
        step;
        out_ready = 1;
        step;
        out_ready = 0;
        chk("snap_a", out_a, 32'hAAAA_AAAA);
        chk("snap_b", out_b, 32'hAAAA_AAAA);

        // Reset mid-stream with two entries buffered
        req_valid = 1; rs_a = 9; rs_b = 5;
        step; step;
        req_valid = 0;
        chk("pre_rst_ready", req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", req_ready, 1);
        chk("mrst_a", out_a, 0);
        chk("mrst_b", out_b, 0);
        chk("mrst_cnt", rd_count, 0);
        step;
        rst_n = 1'b1;
        req_valid = 1; rs_a = 9; rs_b = 0;
        step;
        req_valid = 0;
        chk("post_rst_cnt", rd_count, 1);
        chk("post_rst_a", out_a, 32'hDEAD_BEEF);
        step; step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
